// File: rtl/dice_pkg.sv
// Shared constants and types for the die-roll seven-segment decoder.
// Segment codes are active-low {g,f,e,d,c,b,a}; face 0 means none/invalid.
package dice_pkg;

   localparam logic [6:0] SEG_ONE   = 7'h79;
   localparam logic [6:0] SEG_TWO   = 7'h24;
   localparam logic [6:0] SEG_THREE = 7'h30;
   localparam logic [6:0] SEG_FOUR  = 7'h19;
   localparam logic [6:0] SEG_FIVE  = 7'h12;
   localparam logic [6:0] SEG_SIX   = 7'h02;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef logic [3:0] face_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_SETTLE,
      ST_LOCKED
   } state_t;

   function automatic face_t seg2face(input logic [6:0] s);
      face_t f;
      case (s)
         SEG_ONE:   f = 4'd1;
         SEG_TWO:   f = 4'd2;
         SEG_THREE: f = 4'd3;
         SEG_FOUR:  f = 4'd4;
         SEG_FIVE:  f = 4'd5;
         SEG_SIX:   f = 4'd6;
         default:   f = 4'd0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Debounces the segment bus: registers each sample and strobes acceptance once.
// Ports: clk, reset (sync, active-low), segments in; acc_pattern, acc_stb out.
module seg_stable_filter
   import dice_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] segments,
   output logic [6:0] acc_pattern,
   output logic       acc_stb
);

   localparam logic [3:0] CMAX = 4'(STABLE_CYCLES - 1);

   logic [6:0] sample;
   logic [3:0] cnt;
   logic       fired;
   logic       same;

   assign same        = (segments == sample);
   assign acc_pattern = sample;
   // fired blocks repeat strobes while a saturated pattern is held
   assign acc_stb     = same && (cnt == CMAX) && !fired;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sample <= SEG_BLANK;
         cnt    <= 4'd0;
         fired  <= 1'b0;
      end else begin
         sample <= segments;
         if (same) begin
            if (cnt != CMAX) cnt <= cnt + 4'd1;
         end else begin
            cnt <= 4'd0;
         end
         if (!same)       fired <= 1'b0;
         else if (acc_stb) fired <= 1'b1;
      end
   end

endmodule

// File: rtl/dice_seg_decode.sv
// Decodes a debounced die display into a face, roll pulses and statistics.
// Ports: clk, reset, segments, clr_stats, tally_sel in; face, flags, counters out.
module dice_seg_decode
   import dice_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] segments,
   input  logic       clr_stats,
   input  logic [2:0] tally_sel,
   output logic [3:0] face,
   output logic       face_valid,
   output logic       new_roll,
   output logic       bad_code,
   output logic [7:0] tally_out,
   output logic [9:0] total_rolls,
   output logic [7:0] bad_count
);

   state_t          state;
   logic [6:0]      acc_pattern;
   logic            acc_stb;
   logic [6:0]      last_pat;
   logic            has_last;
   logic [5:0][7:0] tally;
   face_t           acc_face;
   logic            repeat_acc;
   logic            roll_now;
   logic            bad_now;

   seg_stable_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clk        (clk),
      .reset      (reset),
      .segments   (segments),
      .acc_pattern(acc_pattern),
      .acc_stb    (acc_stb)
   );

   assign acc_face   = seg2face(acc_pattern);
   // re-accepting the last pattern (e.g. after a glitch) is silent
   assign repeat_acc = has_last && (acc_pattern == last_pat);
   assign roll_now   = acc_stb && !repeat_acc && (acc_face != 4'd0);
   assign bad_now    = acc_stb && !repeat_acc && (acc_face == 4'd0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_EMPTY;
         last_pat    <= SEG_BLANK;
         has_last    <= 1'b0;
         face        <= 4'd0;
         face_valid  <= 1'b0;
         new_roll    <= 1'b0;
         bad_code    <= 1'b0;
         tally       <= '0;
         total_rolls <= 10'd0;
         bad_count   <= 8'd0;
      end else begin
         new_roll <= roll_now;
         bad_code <= bad_now;

         if (acc_stb) begin
            state <= ST_LOCKED;
         end else begin
            unique case (state)
               ST_EMPTY:  state <= ST_SETTLE;
               ST_SETTLE: state <= ST_SETTLE;
               ST_LOCKED:
                  if (segments != last_pat) state <= ST_SETTLE;
               default:   state <= ST_EMPTY;
            endcase
         end

         if (acc_stb) begin
            has_last <= 1'b1;
            last_pat <= acc_pattern;
         end

         if (roll_now) begin
            face       <= acc_face;
            face_valid <= 1'b1;
         end else if (bad_now) begin
            face       <= 4'd0;
            face_valid <= 1'b0;
         end

         // a clear wins over any coincident count
         if (clr_stats) begin
            tally       <= '0;
            total_rolls <= 10'd0;
            bad_count   <= 8'd0;
         end else begin
            if (roll_now && total_rolls != 10'h3FF)
               total_rolls <= total_rolls + 10'd1;
            if (bad_now && bad_count != 8'hFF)
               bad_count <= bad_count + 8'd1;
            for (int i = 0; i < 6; i++) begin
               if (roll_now && acc_face == 4'(i + 1) &&
                   tally[i] != 8'hFF)
                  tally[i] <= tally[i] + 8'd1;
            end
         end
      end
   end

   always_comb begin
      tally_out = 8'd0;
      case (tally_sel)
         3'd1:    tally_out = tally[0];
         3'd2:    tally_out = tally[1];
         3'd3:    tally_out = tally[2];
         3'd4:    tally_out = tally[3];
         3'd5:    tally_out = tally[4];
         3'd6:    tally_out = tally[5];
         default: tally_out = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_dice_seg_decode.sv
// Directed bench for dice_seg_decode: table of hold vectors plus
// hand-written reset, clear and saturation sequences.
module tb_dice_seg_decode;

   logic       clk;
   logic       reset;
   logic [6:0] segments;
   logic       clr_stats;
   logic [2:0] tally_sel;
   logic [3:0] face;
   logic       face_valid;
   logic       new_roll;
   logic       bad_code;
   logic [7:0] tally_out;
   logic [9:0] total_rolls;
   logic [7:0] bad_count;

   int compared;
   int mismatched;
   int n_new;
   int n_bad;

   typedef struct {
      logic [6:0] seg;
      int         n;
      logic [2:0] tsel;
      int         e_new;
      int         e_bad;
      logic [3:0] e_face;
      logic       e_valid;
      logic [9:0] e_total;
      logic [7:0] e_badc;
      logic [7:0] e_tally;
   } vec_t;

   vec_t vecs [15];

   dice_seg_decode #(.STABLE_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .segments   (segments),
      .clr_stats  (clr_stats),
      .tally_sel  (tally_sel),
      .face       (face),
      .face_valid (face_valid),
      .new_roll   (new_roll),
      .bad_code   (bad_code),
      .tally_out  (tally_out),
      .total_rolls(total_rolls),
      .bad_count  (bad_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (new_roll) n_new++;
      if (bad_code) n_bad++;
   endtask

   task automatic hold(input logic [6:0] s, input int n);
      segments = s;
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      n_new      = 0;
      n_bad      = 0;
      reset      = 1'b0;
      segments   = 7'h7F;
      clr_stats  = 1'b0;
      tally_sel  = 3'd3;

      //        seg   n  ts new bad face v total badc tally
      vecs[0]  = '{7'h02, 2, 3'd3, 0, 0, 4'd3, 1'b1, 10'd1, 8'd0, 8'd1};
      vecs[1]  = '{7'h30, 6, 3'd3, 0, 0, 4'd3, 1'b1, 10'd1, 8'd0, 8'd1};
      vecs[2]  = '{7'h7F, 5, 3'd3, 0, 1, 4'd0, 1'b0, 10'd1, 8'd1, 8'd1};
      vecs[3]  = '{7'h30, 5, 3'd3, 1, 0, 4'd3, 1'b1, 10'd2, 8'd1, 8'd2};
      vecs[4]  = '{7'h30, 4, 3'd3, 0, 0, 4'd3, 1'b1, 10'd2, 8'd1, 8'd2};
      vecs[5]  = '{7'h79, 3, 3'd1, 0, 0, 4'd3, 1'b1, 10'd2, 8'd1, 8'd0};
      vecs[6]  = '{7'h30, 5, 3'd3, 0, 0, 4'd3, 1'b1, 10'd2, 8'd1, 8'd2};
      vecs[7]  = '{7'h7F, 5, 3'd3, 0, 1, 4'd0, 1'b0, 10'd2, 8'd2, 8'd2};
      vecs[8]  = '{7'h30, 5, 3'd3, 1, 0, 4'd3, 1'b1, 10'd3, 8'd2, 8'd3};
      vecs[9]  = '{7'h12, 5, 3'd5, 1, 0, 4'd5, 1'b1, 10'd4, 8'd2, 8'd1};
      vecs[10] = '{7'h55, 5, 3'd5, 0, 1, 4'd0, 1'b0, 10'd4, 8'd3, 8'd1};
      vecs[11] = '{7'h02, 5, 3'd6, 1, 0, 4'd6, 1'b1, 10'd5, 8'd3, 8'd1};
      vecs[12] = '{7'h19, 5, 3'd4, 1, 0, 4'd4, 1'b1, 10'd6, 8'd3, 8'd1};
      vecs[13] = '{7'h19, 1, 3'd7, 0, 0, 4'd4, 1'b1, 10'd6, 8'd3, 8'd0};
      vecs[14] = '{7'h19, 1, 3'd0, 0, 0, 4'd4, 1'b1, 10'd6, 8'd3, 8'd0};

      // reset state
      tick();
      tick();
      check("rst_face", face, 0);
      check("rst_valid", face_valid, 0);
      check("rst_new", new_roll, 0);
      check("rst_bad", bad_code, 0);
      check("rst_total", total_rolls, 0);
      check("rst_badc", bad_count, 0);
      check("rst_tally", tally_out, 0);

      // first acceptance latency: visible after the fifth edge
      reset    = 1'b1;
      segments = 7'h30;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("lat_new%0d", k), new_roll, (k == 4) ? 1 : 0);
      end
      check("lat_face", face, 3);
      check("lat_valid", face_valid, 1);
      check("lat_total", total_rolls, 1);
      check("lat_tally3", tally_out, 1);

      foreach (vecs[i]) begin
         n_new     = 0;
         n_bad     = 0;
         tally_sel = vecs[i].tsel;
         hold(vecs[i].seg, vecs[i].n);
         check($sformatf("v%0d_new", i), n_new, vecs[i].e_new);
         check($sformatf("v%0d_bad", i), n_bad, vecs[i].e_bad);
         check($sformatf("v%0d_face", i), face, vecs[i].e_face);
         check($sformatf("v%0d_valid", i), face_valid, vecs[i].e_valid);
         check($sformatf("v%0d_total", i), total_rolls, vecs[i].e_total);
         check($sformatf("v%0d_badc", i), bad_count, vecs[i].e_badc);
         check($sformatf("v%0d_tally", i), tally_out, vecs[i].e_tally);
      end

      // reset in the middle of settling 7'h12
      tally_sel = 3'd4;
      hold(7'h12, 2);
      reset = 1'b0;
      tick();
      check("mid_face", face, 0);
      check("mid_valid", face_valid, 0);
      check("mid_total", total_rolls, 0);
      check("mid_badc", bad_count, 0);
      check("mid_tally4", tally_out, 0);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("mid_new%0d", k), new_roll, (k == 4) ? 1 : 0);
      end
      check("mid_face5", face, 5);

      // clear coinciding with a new_roll edge
      tally_sel = 3'd5;
      hold(7'h24, 4);
      clr_stats = 1'b1;
      tick();
      check("clr_new", new_roll, 1);
      check("clr_face", face, 2);
      check("clr_total", total_rolls, 0);
      check("clr_badc", bad_count, 0);
      check("clr_tally5", tally_out, 0);
      clr_stats = 1'b0;
      tally_sel = 3'd2;
      tick();
      check("clr_new_after", new_roll, 0);
      check("clr_tally2", tally_out, 0);

      // tally saturation
      n_new = 0;
      for (int p = 0; p < 300; p++) begin
         hold(7'h79, 5);
         hold(7'h24, 5);
      end
      check("sat_pulses", n_new, 600);
      check("sat_total", total_rolls, 600);
      tally_sel = 3'd1;
      #1;
      check("sat_tally1", tally_out, 255);
      tally_sel = 3'd2;
      #1;
      check("sat_tally2", tally_out, 255);

      // total_rolls saturation
      n_new = 0;
      for (int p = 0; p < 212; p++) begin
         hold(7'h79, 5);
         hold(7'h24, 5);
      end
      check("sat2_pulses", n_new, 424);
      check("sat2_total", total_rolls, 1023);

      // bad_count saturation with two distinct invalid patterns
      n_bad = 0;
      for (int p = 0; p < 130; p++) begin
         hold(7'h7F, 5);
         hold(7'h55, 5);
      end
      check("satb_pulses", n_bad, 260);
      check("satb_badc", bad_count, 255);
      check("satb_face", face, 0);
      check("satb_valid", face_valid, 0);

      // plain clear without a pulse
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("clr2_total", total_rolls, 0);
      check("clr2_badc", bad_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
